// File: rtl/ipd_ctrl_sat_pkg.sv
// Shared types and helpers for the saturating I-PD/PID servo controller.
package ipd_ctrl_sat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAMPLE   = 3'd1,
    ST_MUL      = 3'd2,
    ST_ACC      = 3'd3,
    ST_OUT      = 3'd4,
    ST_WAIT_LOW = 3'd5
  } state_t;

  // Accumulator width: a W x (W+1) product plus headroom for summing three terms.
  function automatic int acc_w(input int w);
    return 2 * w + 4;
  endfunction

  function automatic logic signed [63:0] clamp64(input logic signed [63:0] v,
                                                 input logic signed [63:0] lo,
                                                 input logic signed [63:0] hi);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/ipd_ctrl_sat_if.sv
// Sample/gain/result bundle between the sample receiver, the controller and the PWM stage.
// Handshake: Rx_En high in IDLE starts one sample; Busy stays high until Rx_En is seen low
// after the result; Y_Vld pulses for exactly one cycle when Yk/Sat take a new value.
interface ipd_ctrl_sat_if #(
    parameter int W     = 16,
    parameter int OUT_W = 16
);
    logic                    Rx_En;
    logic signed [W-1:0]     Pot;
    logic signed [W-1:0]     Ref;
    logic                    Mode;
    logic                    Ld_Gain;
    logic signed [W-1:0]     Kp_In;
    logic signed [W-1:0]     Ki_In;
    logic signed [W-1:0]     Kd_In;
    logic signed [OUT_W-1:0] Yk;
    logic                    Y_Vld;
    logic                    Busy;
    logic                    Sat;

    modport master (
        output Rx_En, Pot, Ref, Mode, Ld_Gain, Kp_In, Ki_In, Kd_In,
        input  Yk, Y_Vld, Busy, Sat
    );

    modport slave (
        input  Rx_En, Pot, Ref, Mode, Ld_Gain, Kp_In, Ki_In, Kd_In,
        output Yk, Y_Vld, Busy, Sat
    );
endinterface

// File: rtl/ipd_ctrl_sat_sat.sv
// Combinational signed saturator: clips IN_W bits to the OUT_W two's-complement range.
module ipd_ctrl_sat_sat #(
    parameter int IN_W  = 36,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);
    // The value fits only when every bit above the output sign bit repeats it.
    always_comb begin
        clip = !((&din[IN_W-1:OUT_W-1]) || (~|din[IN_W-1:OUT_W-1]));
        if (!clip)
            dout = din[OUT_W-1:0];
        else if (din[IN_W-1])
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        else
            dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
endmodule

// File: rtl/ipd_ctrl_sat.sv
// Multi-cycle I-PD/PID servo controller with loadable gains, integrator anti-windup and
// output saturation. One result per Rx_En strobe, four edges after the strobe is seen.
module ipd_ctrl_sat
    import ipd_ctrl_sat_pkg::*;
#(
    parameter int W     = 16,
    parameter int FRAC  = 0,
    parameter int OUT_W = 16,
    parameter int I_LIM = 30000,
    parameter int KP0   = 18,
    parameter int KI0   = 7,
    parameter int KD0   = 150
) (
    input  logic           Clk_G,
    input  logic           Rst_G,
    ipd_ctrl_sat_if.slave  bus,
    output state_t         Dbg_State
);
    localparam int ACC_W = acc_w(W);
    localparam int WE    = W + 1;

    state_t state_q, state_d;

    logic signed [W-1:0]     kp_r, ki_r, kd_r;
    logic signed [WE-1:0]    ek_r, dp_r;
    logic signed [W-1:0]     pot_s, pot_prev;
    logic                    mode_s;
    logic signed [ACC_W-1:0] p_r, d_r, kie_r, i_r, s_r;
    logic signed [ACC_W-1:0] i_new, s_shift;
    logic signed [WE-1:0]    p_sel;
    logic signed [OUT_W-1:0] yk_r, yk_sat;
    logic                    sat_r, vld_r, clip;

    always_ff @(posedge Clk_G) begin
        if (!Rst_G) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.Rx_En) state_d = ST_SAMPLE;
            ST_SAMPLE:   state_d = ST_MUL;
            ST_MUL:      state_d = ST_ACC;
            ST_ACC:      state_d = ST_OUT;
            ST_OUT:      state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!bus.Rx_En) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // P acts on the error only in PID mode; I-PD keeps P on the measurement.
    always_comb begin
        p_sel   = mode_s ? ek_r : WE'(pot_s);
        i_new   = ACC_W'(clamp64(64'(i_r + kie_r), 64'(-I_LIM), 64'(I_LIM)));
        s_shift = s_r >>> FRAC;
    end

    ipd_ctrl_sat_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat (
        .din  (s_shift),
        .dout (yk_sat),
        .clip (clip)
    );

    always_ff @(posedge Clk_G) begin
        if (!Rst_G) begin
            kp_r     <= W'(KP0);
            ki_r     <= W'(KI0);
            kd_r     <= W'(KD0);
            ek_r     <= '0;
            dp_r     <= '0;
            pot_s    <= '0;
            pot_prev <= '0;
            mode_s   <= 1'b0;
            p_r      <= '0;
            d_r      <= '0;
            kie_r    <= '0;
            i_r      <= '0;
            s_r      <= '0;
            yk_r     <= '0;
            sat_r    <= 1'b0;
            vld_r    <= 1'b0;
        end else begin
            vld_r <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.Ld_Gain) begin
                        kp_r <= bus.Kp_In;
                        ki_r <= bus.Ki_In;
                        kd_r <= bus.Kd_In;
                    end
                end
                ST_SAMPLE: begin
                    ek_r   <= WE'(bus.Ref) - WE'(bus.Pot);
                    dp_r   <= WE'(bus.Pot) - WE'(pot_prev);
                    pot_s  <= bus.Pot;
                    mode_s <= bus.Mode;
                end
                ST_MUL: begin
                    p_r   <= ACC_W'(kp_r) * ACC_W'(p_sel);
                    d_r   <= ACC_W'(kd_r) * ACC_W'(dp_r);
                    kie_r <= ACC_W'(ki_r) * ACC_W'(ek_r);
                end
                ST_ACC: begin
                    i_r      <= i_new;
                    pot_prev <= pot_s;
                    s_r      <= i_new - p_r - d_r;
                end
                ST_OUT: begin
                    yk_r  <= yk_sat;
                    sat_r <= clip;
                    vld_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Yk    = yk_r;
    assign bus.Sat   = sat_r;
    assign bus.Y_Vld = vld_r;
    assign bus.Busy  = (state_q != ST_IDLE);
    assign Dbg_State = state_q;
endmodule

// File: tb/tb_ipd_ctrl_sat.sv
// Self-checking bench for ipd_ctrl_sat: behavioural model feeds an expected-result queue.
module tb_ipd_ctrl_sat;
  import ipd_ctrl_sat_pkg::*;

  logic   clk_g;
  logic   rst_g;
  state_t dbg_state;

  ipd_ctrl_sat_if #(.W(16), .OUT_W(16)) bus ();

  ipd_ctrl_sat #(.W(16), .FRAC(0), .OUT_W(16), .I_LIM(30000),
                 .KP0(18), .KI0(7), .KD0(150)) dut (
    .Clk_G     (clk_g),
    .Rst_G     (rst_g),
    .bus       (bus),
    .Dbg_State (dbg_state)
  );

  // clock / reset
  initial clk_g = 1'b0;
  always #5 clk_g = ~clk_g;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {Sat, Yk}
  logic [16:0] exp_q[$];

  // reference model state
  longint i_m, pp_m, kp_m, ki_m, kd_m;

  task automatic model_reset();
    i_m = 0; pp_m = 0; kp_m = 18; ki_m = 7; kd_m = 150;
  endtask

  function automatic logic [16:0] model_step(input longint r, input longint p, input bit m);
    longint ek, pt, dt, s;
    logic signed [15:0] y;
    logic sat;
    ek  = r - p;
    pt  = kp_m * (m ? ek : p);
    dt  = kd_m * (p - pp_m);
    i_m = i_m + ki_m * ek;
    if (i_m > 30000)  i_m = 30000;
    if (i_m < -30000) i_m = -30000;
    pp_m = p;
    s = i_m - pt - dt;
    sat = 1'b1;
    if (s > 32767)       y = 16'sd32767;
    else if (s < -32768) y = -16'sd32768;
    else begin
      y = 16'(s);
      sat = 1'b0;
    end
    return {sat, y};
  endfunction

  // driver tasks
  task automatic apply_reset();
    @(negedge clk_g);
    rst_g = 1'b0;
    bus.Rx_En = 1'b0;
    bus.Ld_Gain = 1'b0;
    @(negedge clk_g);
    rst_g = 1'b1;
    model_reset();
    n_checks += 4;
    if (bus.Yk !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_yk: got %0d, required 0", bus.Yk);
    end
    if (bus.Y_Vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vld: got %0b, required 0", bus.Y_Vld);
    end
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %0b, required 0", bus.Busy);
    end
    if (bus.Sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sat: got %0b, required 0", bus.Sat);
    end
  endtask

  task automatic run_sample(input int r, input int p, input bit m, input bit ld,
                            input int kp, input int ki, input int kd);
    int cyc;
    logic [16:0] e;
    @(negedge clk_g);
    bus.Ref = 16'(r); bus.Pot = 16'(p); bus.Mode = m;
    bus.Ld_Gain = ld; bus.Kp_In = 16'(kp); bus.Ki_In = 16'(ki); bus.Kd_In = 16'(kd);
    bus.Rx_En = 1'b1;
    if (ld) begin kp_m = kp; ki_m = ki; kd_m = kd; end
    exp_q.push_back(model_step(r, p, m));
    cyc = 0;
    do begin
      @(negedge clk_g);
      cyc++;
      bus.Ld_Gain = 1'b0;
    end while (bus.Y_Vld !== 1'b1 && cyc < 12);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.Y_Vld !== 1'b1) begin
      n_fail++;
      $display("FAIL y_vld_timeout: no Y_Vld within %0d cycles, required one", cyc);
    end else begin
      n_checks += 3;
      if (cyc != 5) begin
        n_fail++;
        $display("FAIL latency: Y_Vld after %0d edges, required 5", cyc);
      end
      if ({bus.Sat, bus.Yk} !== e) begin
        n_fail++;
        $display("FAIL result: got Yk=%0d Sat=%0b, required Yk=%0d Sat=%0b",
                 bus.Yk, bus.Sat, $signed(e[15:0]), e[16]);
      end
      if (bus.Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_at_vld: got %0b, required 1", bus.Busy);
      end
    end
    bus.Rx_En = 1'b0;
    @(negedge clk_g);
    n_checks += 2;
    if (bus.Y_Vld !== 1'b0) begin
      n_fail++;
      $display("FAIL y_vld_pulse: got %0b one cycle later, required 0", bus.Y_Vld);
    end
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_release: got %0b, required 0", bus.Busy);
    end
  endtask

  // scenario tasks
  task automatic test_basic();
    apply_reset();
    run_sample(100, 0, 1'b0, 1'b0, 0, 0, 0);
    run_sample(100, 10, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_windup();
    apply_reset();
    for (int k = 0; k < 5; k++) run_sample(1000, 0, 1'b0, 1'b0, 0, 0, 0);
    run_sample(0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    apply_reset();
    run_sample(0, -2000, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_handshake();
    int pulses;
    logic [16:0] e;
    apply_reset();
    @(negedge clk_g);
    bus.Ref = 16'sd200; bus.Pot = 16'sd30; bus.Mode = 1'b0;
    bus.Rx_En = 1'b1;
    exp_q.push_back(model_step(200, 30, 1'b0));
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_g);
      if (c == 2) begin
        bus.Ld_Gain = 1'b1;
        bus.Kp_In = 16'sd1; bus.Ki_In = 16'sd1; bus.Kd_In = 16'sd1;
      end else begin
        bus.Ld_Gain = 1'b0;
      end
      if (bus.Y_Vld === 1'b1) begin
        pulses++;
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.Sat, bus.Yk} !== e) begin
          n_fail++;
          $display("FAIL hold_result: got Yk=%0d, required %0d", bus.Yk, $signed(e[15:0]));
        end
      end
      n_checks++;
      if (bus.Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_busy: cycle %0d got %0b, required 1", c, bus.Busy);
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL hold_pulses: got %0d Y_Vld pulses, required 1", pulses);
    end
    bus.Rx_En = 1'b0;
    @(negedge clk_g);
    n_checks++;
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got %0b, required 0", bus.Busy);
    end
    run_sample(150, 40, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_mode_and_reset();
    int vld_seen;
    apply_reset();
    run_sample(50, 20, 1'b1, 1'b1, 2, 0, 0);
    @(negedge clk_g);
    bus.Ref = 16'sd50; bus.Pot = 16'sd20; bus.Mode = 1'b1;
    bus.Rx_En = 1'b1;
    @(negedge clk_g);
    @(negedge clk_g);
    n_checks++;
    if (dbg_state !== ST_MUL) begin
      n_fail++;
      $display("FAIL reset_point: state %0d, required MUL", dbg_state);
    end
    rst_g = 1'b0;
    bus.Rx_En = 1'b0;
    @(negedge clk_g);
    n_checks += 3;
    if (bus.Yk !== 16'sd0) begin
      n_fail++;
      $display("FAIL mid_reset_yk: got %0d, required 0", bus.Yk);
    end
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_busy: got %0b, required 0", bus.Busy);
    end
    if (bus.Y_Vld !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_vld: got %0b, required 0", bus.Y_Vld);
    end
    rst_g = 1'b1;
    model_reset();
    vld_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_g);
      if (bus.Y_Vld === 1'b1) vld_seen++;
    end
    n_checks++;
    if (vld_seen != 0) begin
      n_fail++;
      $display("FAIL discarded_sample: got %0d Y_Vld pulses, required 0", vld_seen);
    end
  endtask

  task automatic test_random(input int n);
    int r, p;
    bit m;
    apply_reset();
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(6000)) - 3000;
      p = int'($urandom_range(6000)) - 3000;
      m = 1'($urandom_range(1));
      run_sample(r, p, m, 1'b0, 0, 0, 0);
    end
  endtask

  initial begin
    rst_g = 1'b0;
    bus.Rx_En = 1'b0; bus.Ld_Gain = 1'b0; bus.Mode = 1'b0;
    bus.Ref = '0; bus.Pot = '0;
    bus.Kp_In = '0; bus.Ki_In = '0; bus.Kd_In = '0;
    model_reset();
    test_basic();
    test_windup();
    test_saturation();
    test_handshake();
    test_mode_and_reset();
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    if (n_fail == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end
endmodule
